pc_stack: RTL and testbench



---
 rtl/pc_pkg.sv | 17 +
 rtl/pc_ret_stack.sv | 50 +++++
 rtl/pc_stack.sv | 137 +++++++++++++
 tb/tb_pc_stack.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared types and defaults for the program counter slice.
// Next-PC source encoding plus default reset/interrupt addresses.
package pc_pkg;

  typedef enum logic [2:0] {
    NPC_INC,
    NPC_JUMP,
    NPC_CALL,
    NPC_RET,
    NPC_IRQ,
    NPC_HOLD
  } npc_src_e;

  localparam logic [31:0] DEF_RESET_ADDR = 32'h0000_0000;
  localparam logic [31:0] DEF_IRQ_VECTOR = 32'h0000_0800;

endpackage

// File: rtl/pc_ret_stack.sv
// pc_ret_stack: parametrised return-address LIFO.
// Push and pop are ignored when full / empty respectively.
module pc_ret_stack
  import pc_pkg::*;
#(
  parameter int W     = 12,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_data,
  output logic [W-1:0]  o_top,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  logic [W-1:0]  r_mem [0:(2**CW)-1];
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty & ~i_push;
  assign o_top     = r_mem[r_count - CW'(1)];
  assign o_count   = r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_do_push) begin
      r_count <= r_count + CW'(1);
    end else if (w_do_pop) begin
      r_count <= r_count - CW'(1);
    end
  end

  // Contents need no reset; only the count defines validity.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_count] <= i_data;
    end
  end

endmodule

// File: rtl/pc_stack.sv
// pc_stack: program counter with hardware return-address stack.
// Optional interrupt entry enabled by defining PC_INTERRUPT_EN.
module pc_stack
  import pc_pkg::*;
#(
  parameter int              ADDR_W      = 12,
  parameter int              STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(DEF_RESET_ADDR),
  parameter logic [ADDR_W-1:0] IRQ_VECTOR = ADDR_W'(DEF_IRQ_VECTOR),
  localparam int             CW          = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              jumpSelect,
  input  logic              callSelect,
  input  logic              returnSelect,
  input  logic [ADDR_W-1:0] jumpAddr,
  input  logic              clr_err,
  input  logic              irq_req,
  output logic [ADDR_W-1:0] PCaddr,
  output logic [CW-1:0]     stack_count,
  output logic              ovf_err,
  output logic              unf_err,
  output logic              irq_ack
);

  logic [ADDR_W-1:0] r_pc;
  logic              r_ovf;
  logic              r_unf;
  logic              r_ack;

  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_top;
  logic [ADDR_W-1:0] w_npc;
  logic [ADDR_W-1:0] w_push_data;
  logic              w_full;
  logic              w_empty;
  logic              w_irq;
  logic              w_push;
  logic              w_pop;
  logic              w_ovf;
  logic              w_unf;
  logic              w_ack;
  npc_src_e          w_src;

`ifdef PC_INTERRUPT_EN
  assign w_irq = irq_req;
`else
  logic              w_unused_irq;
  logic [ADDR_W-1:0] w_unused_vec;
  assign w_unused_irq = irq_req;
  assign w_unused_vec = IRQ_VECTOR;
  assign w_irq        = 1'b0;
`endif

  assign w_pc_inc = r_pc + ADDR_W'(1);

  // Fixed priority: IRQ > return > call > jump > increment.
  always_comb begin
    w_src = NPC_INC;
    w_ovf = 1'b0;
    w_unf = 1'b0;
    if (w_irq) begin
      w_src = w_full ? NPC_HOLD : NPC_IRQ;
      w_ovf = w_full;
    end else if (returnSelect) begin
      w_src = w_empty ? NPC_HOLD : NPC_RET;
      w_unf = w_empty;
    end else if (callSelect) begin
      w_src = w_full ? NPC_HOLD : NPC_CALL;
      w_ovf = w_full;
    end else if (jumpSelect) begin
      w_src = NPC_JUMP;
    end
  end

  always_comb begin
    w_npc = w_pc_inc;
    unique case (w_src)
      NPC_INC:  w_npc = w_pc_inc;
      NPC_JUMP: w_npc = jumpAddr;
      NPC_CALL: w_npc = jumpAddr;
      NPC_RET:  w_npc = w_top;
`ifdef PC_INTERRUPT_EN
      NPC_IRQ:  w_npc = IRQ_VECTOR;
`else
      NPC_IRQ:  w_npc = r_pc;
`endif
      NPC_HOLD: w_npc = r_pc;
      default:  w_npc = r_pc;
    endcase
  end

  assign w_push      = enable & ((w_src == NPC_CALL) | (w_src == NPC_IRQ));
  assign w_pop       = enable & (w_src == NPC_RET);
  assign w_ack       = enable & (w_src == NPC_IRQ);
  assign w_push_data = (w_src == NPC_IRQ) ? r_pc : w_pc_inc;

  pc_ret_stack #(
    .W     (ADDR_W),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_push_data),
    .o_top   (w_top),
    .o_count (stack_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // A fresh error in the same cycle as clr_err wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc  <= RESET_ADDR;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
      r_ack <= 1'b0;
    end else begin
      if (enable) begin
        r_pc <= w_npc;
      end
      r_ovf <= (enable & w_ovf) | (r_ovf & ~clr_err);
      r_unf <= (enable & w_unf) | (r_unf & ~clr_err);
      r_ack <= w_ack;
    end
  end

  assign PCaddr  = r_pc;
  assign ovf_err = r_ovf;
  assign unf_err = r_unf;
  assign irq_ack = r_ack;

endmodule

// File: tb/tb_pc_stack.sv
// tb_pc_stack: directed and random checks of pc_stack against a
// queue-based reference model.
module tb_pc_stack;

`ifdef PC_INTERRUPT_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, enable, jumpSelect, callSelect, returnSelect;
  logic        clr_err, irq_req;
  logic [11:0] jumpAddr;
  logic [11:0] PCaddr;
  logic [2:0]  stack_count;
  logic        ovf_err, unf_err, irq_ack;

  int errors = 0;
  int checks = 0;

  logic [11:0] q[$];
  logic [11:0] m_pc;
  logic        m_ovf, m_unf, m_ack;

  always #5 clk = ~clk;

  pc_stack dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .jumpSelect   (jumpSelect),
    .callSelect   (callSelect),
    .returnSelect (returnSelect),
    .jumpAddr     (jumpAddr),
    .clr_err      (clr_err),
    .irq_req      (irq_req),
    .PCaddr       (PCaddr),
    .stack_count  (stack_count),
    .ovf_err      (ovf_err),
    .unf_err      (unf_err),
    .irq_ack      (irq_ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: apply the spec's rules to an abstract stack queue.
  task automatic model(input bit rs, en, j, c, r, clr, irq,
                       input logic [11:0] a);
    bit new_ovf, new_unf;
    new_ovf = 0;
    new_unf = 0;
    m_ack   = 0;
    if (rs) begin
      q.delete();
      m_pc  = 12'h000;
      m_ovf = 0;
      m_unf = 0;
      return;
    end
    if (en) begin
      if (IRQ_EN && irq) begin
        if (q.size() == 4) new_ovf = 1;
        else begin
          q.push_back(m_pc);
          m_pc  = 12'h800;
          m_ack = 1;
        end
      end else if (r) begin
        if (q.size() == 0) new_unf = 1;
        else m_pc = q.pop_back();
      end else if (c) begin
        if (q.size() == 4) new_ovf = 1;
        else begin
          q.push_back(m_pc + 12'd1);
          m_pc = a;
        end
      end else if (j) m_pc = a;
      else m_pc = m_pc + 12'd1;
    end
    m_ovf = new_ovf | (m_ovf & ~clr);
    m_unf = new_unf | (m_unf & ~clr);
  endtask

  task automatic step(input string tag, input bit rs, en, j, c, r,
                      clr, irq, input logic [11:0] a);
    @(negedge clk);
    reset        = rs;
    enable       = en;
    jumpSelect   = j;
    callSelect   = c;
    returnSelect = r;
    clr_err      = clr;
    irq_req      = irq;
    jumpAddr     = a;
    model(rs, en, j, c, r, clr, irq, a);
    @(posedge clk);
    #1;
    chk({tag, ".pc"},  32'(PCaddr),      32'(m_pc));
    chk({tag, ".cnt"}, 32'(stack_count), 32'(q.size()));
    chk({tag, ".ovf"}, 32'(ovf_err),     32'(m_ovf));
    chk({tag, ".unf"}, 32'(unf_err),     32'(m_unf));
    chk({tag, ".ack"}, 32'(irq_ack),     32'(m_ack));
  endtask

  //               tag      rs en j  c  r  clr irq addr
  initial begin
    step("rst",     1, 0, 0, 0, 0, 0, 0, 12'h000);
    chk("rst_pc", 32'(PCaddr), 32'h000);
    step("inc1",    0, 1, 0, 0, 0, 0, 0, 12'h000);
    step("inc2",    0, 1, 0, 0, 0, 0, 0, 12'h000);
    step("inc3",    0, 1, 0, 0, 0, 0, 0, 12'h000);
    chk("t1_pc", 32'(PCaddr), 32'h003);
    step("inc4",    0, 1, 0, 0, 0, 0, 0, 12'h000);
    step("inc5",    0, 1, 0, 0, 0, 0, 0, 12'h000);
    step("call1",   0, 1, 0, 1, 0, 0, 0, 12'h100);
    chk("t2_call_pc", 32'(PCaddr), 32'h100);
    chk("t2_call_cnt", 32'(stack_count), 32'd1);
    step("sub1",    0, 1, 0, 0, 0, 0, 0, 12'h000);
    step("sub2",    0, 1, 0, 0, 0, 0, 0, 12'h000);
    step("ret1",    0, 1, 0, 0, 1, 0, 0, 12'h000);
    chk("t2_ret_pc", 32'(PCaddr), 32'h006);
    for (int i = 0; i < 4; i++)
      step("nest", 0, 1, 0, 1, 0, 0, 0, 12'(12'h200 + 12'(i) * 12'h100));
    step("call5",   0, 1, 0, 1, 0, 0, 0, 12'h600);
    chk("t3_hold_pc", 32'(PCaddr), 32'h500);
    chk("t3_ovf", 32'(ovf_err), 32'd1);
    step("unw1",    0, 1, 0, 0, 1, 0, 0, 12'h000);
    chk("t3_unw1", 32'(PCaddr), 32'h401);
    step("unw2",    0, 1, 0, 0, 1, 0, 0, 12'h000);
    step("unw3",    0, 1, 0, 0, 1, 0, 0, 12'h000);
    step("unw4",    0, 1, 0, 0, 1, 0, 0, 12'h000);
    chk("t3_unw4", 32'(PCaddr), 32'h007);
    step("unf",     0, 1, 0, 0, 1, 0, 0, 12'h000);
    chk("t4_unf_pc", 32'(PCaddr), 32'h007);
    chk("t4_unf", 32'(unf_err), 32'd1);
    step("clr",     0, 0, 1, 0, 0, 1, 0, 12'h0AA);
    chk("t4_clr", 32'({ovf_err, unf_err}), 32'd0);
    step("hold",    0, 0, 1, 1, 1, 0, 0, 12'h0AA);
    step("jmax",    0, 1, 1, 0, 0, 0, 0, 12'hFFF);
    step("wrap",    0, 1, 0, 0, 0, 0, 0, 12'h000);
    chk("t5_wrap", 32'(PCaddr), 32'h000);
    step("jcall",   0, 1, 1, 1, 0, 0, 0, 12'h123);
    chk("t5_jcall_cnt", 32'(stack_count), 32'd1);
    step("ret2",    0, 1, 0, 0, 1, 0, 0, 12'h000);
    step("unfclr",  0, 1, 0, 0, 1, 1, 0, 12'h000);
    chk("unf_wins", 32'(unf_err), 32'd1);
    step("call_r",  0, 1, 0, 1, 0, 0, 0, 12'h300);
    step("rstmid",  1, 1, 0, 1, 0, 0, 0, 12'h400);
    chk("rst_cnt", 32'(stack_count), 32'd0);
    step("j20",     0, 1, 1, 0, 0, 0, 0, 12'h020);
    step("irq",     0, 1, 1, 0, 0, 0, 1, 12'h055);
    chk("t6_pc", 32'(PCaddr), IRQ_EN ? 32'h800 : 32'h055);
    step("irqoff",  0, 1, 0, 0, 0, 0, 0, 12'h000);
    chk("t6_ack_low", 32'(irq_ack), 32'd0);
    step("irqret",  0, 1, 0, 0, 1, 0, 0, 12'h000);
    for (int i = 0; i < 600; i++) begin
      logic [31:0] rv;
      rv = $urandom;
      step("rnd", rv[31:29] == 3'd0, rv[0] | rv[1] | rv[2],
           rv[3] & rv[4], rv[5] & rv[6], rv[7] & rv[8],
           rv[9] & rv[10] & rv[11], rv[12] & rv[13] & rv[14],
           rv[27:16]);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
